bus_slave_mem: RTL and testbench

BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

---
 rtl/bus_slave_mem_pkg.sv | 26 ++
 rtl/bus_slave_mem_if.sv | 27 ++
 rtl/spm_ram.sv | 37 +++
 rtl/bus_slave_mem.sv | 146 ++++++++++++++
 tb/tb_bus_slave_mem.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_slave_mem_pkg.sv
// rtl/bus_slave_mem_pkg.sv - shared bus types, FSM state enum and bus widths
//
// Purpose : common definitions for the bus slave memory block and its bench.
// Contents: word address/data widths and types, read/write encoding,
//           slave FSM state enum, wait-counter width.
package bus_slave_mem_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int CNT_W       = 4;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

  typedef enum logic {
    BUS_WRITE = 1'b0,
    BUS_READ  = 1'b1
  } bus_rw_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } slave_state_e;

endpackage

// File: rtl/bus_slave_mem_if.sv
// rtl/bus_slave_mem_if.sv - bus handshake interface between master and slave memory
//
// Purpose : bundles the strobe/select, request and response signals.
// Signals : cs_ (chip select, low), as_ (address strobe, low), rw, addr,
//           wr_data from the master; rd_data and rdy_ (low) from the slave.
interface bus_slave_mem_if;
  import bus_slave_mem_pkg::*;

  logic       cs_;
  logic       as_;
  bus_rw_e    rw;
  word_addr_t addr;
  word_data_t wr_data;
  word_data_t rd_data;
  logic       rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );

endinterface

// File: rtl/spm_ram.sv
// rtl/spm_ram.sv - single-port RAM, synchronous write and registered read
//
// Purpose : storage array for bus_slave_mem; no reset on contents or output.
// Ports   : clk       in  clock
//           en_i      in  access enable for this edge
//           we_i      in  1 = write wr_data_i, 0 = read into rd_data_o
//           addr_i    in  word address
//           wr_data_i in  write data
//           rd_data_o out read data, updated only on a read access
module spm_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wr_data_i;
      end else begin
        rd_data_q <= mem_q[addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_slave_mem.sv
// rtl/bus_slave_mem.sv - bus slave memory with programmable wait states
//
// Purpose : accepts one read/write request at a time from the bus, inserts
//           WAIT_CYCLES wait states, accesses spm_ram and answers with a
//           single-cycle rdy_ pulse.
// Ports   : clk   in  system clock, rising edge
//           rst   in  asynchronous active-low reset
//           bus   slave modport: cs_, as_, rw, addr, wr_data in;
//                 rd_data, rdy_ out (rd_data is zero while rdy_ is high so
//                 several slaves can be OR-combined)
module bus_slave_mem
  import bus_slave_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  bus_slave_mem_if.slave bus
);

  // Counter starts at WAIT_CYCLES-1 so the WAIT state lasts WAIT_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  slave_state_e      state_q, state_d;
  logic              accept;
  logic              enter_ack;

  logic [ADDR_W-1:0] addr_q, addr_d;
  bus_rw_e           rw_q, rw_d;
  word_data_t        wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  word_data_t        ram_wr_data;
  word_data_t        ram_rd_data;

  // Upper word-address bits are deliberately ignored (addresses alias).
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[WORD_ADDR_W-1:ADDR_W];

  // Requests are only looked at while idle; WAIT/ACK ignore the bus.
  assign accept = (state_q == ST_IDLE) && !bus.cs_ && !bus.as_;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
    ram_en    = enter_ack;
    // With zero wait states ACK is entered on the accepting edge itself, so
    // the RAM must see the live bus request; otherwise it sees the latch.
    if (state_q == ST_IDLE) begin
      ram_addr    = bus.addr[ADDR_W-1:0];
      ram_we      = (bus.rw == BUS_WRITE);
      ram_wr_data = bus.wr_data;
    end else begin
      ram_addr    = addr_q;
      ram_we      = (rw_q == BUS_WRITE);
      ram_wr_data = wr_data_q;
    end
    // rdy_ is registered out of ACK, so it falls one edge after ACK is
    // entered and has no combinational path from the bus.
    rdy_d = (state_q != ST_ACK);
  end

  // ------------------------------------------------- request latch and counter
  always_comb begin
    addr_d    = addr_q;
    rw_d      = rw_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    if (accept) begin
      addr_d    = bus.addr[ADDR_W-1:0];
      rw_d      = bus.rw;
      wr_data_d = bus.wr_data;
      cnt_d     = CNT_LOAD;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      rw_q      <= BUS_WRITE;
      wr_data_q <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b1;
    end else begin
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
    end
  end

  spm_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_DATA_W)
  ) u_spm_ram (
    .clk       (clk),
    .en_i      (ram_en),
    .we_i      (ram_we),
    .addr_i    (ram_addr),
    .wr_data_i (ram_wr_data),
    .rd_data_o (ram_rd_data)
  );

  // rw_q is still valid during the rdy_ cycle: a new request can only be
  // latched on the edge that ends it.
  assign bus.rdy_    = rdy_q;
  assign bus.rd_data = (!rdy_q && (rw_q == BUS_READ)) ? ram_rd_data : '0;

endmodule

// File: tb/tb_bus_slave_mem.sv
// tb/tb_bus_slave_mem.sv - self-checking bench for bus_slave_mem (wait 0, 1 and 3)
module tb_bus_slave_mem;
  import bus_slave_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst3;
  int   total = 0;
  int   bad   = 0;

  // Reference memory: key = dut select * 1024 + (word address mod 1024).
  word_data_t model [int];

  bus_slave_mem_if bi0 ();
  bus_slave_mem_if bi1 ();
  bus_slave_mem_if bi3 ();

  bus_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bi0.slave));
  bus_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bi1.slave));
  bus_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bi3.slave));

  function automatic int key(input int sel, input word_addr_t a);
    return sel * 1024 + int'(a % 30'd1024);
  endfunction

  task automatic drive(input int sel, input logic cs, input logic as_n, input bus_rw_e rw,
                       input word_addr_t a, input word_data_t d);
    case (sel)
      0: begin bi0.cs_ = cs; bi0.as_ = as_n; bi0.rw = rw; bi0.addr = a; bi0.wr_data = d; end
      1: begin bi1.cs_ = cs; bi1.as_ = as_n; bi1.rw = rw; bi1.addr = a; bi1.wr_data = d; end
      default: begin bi3.cs_ = cs; bi3.as_ = as_n; bi3.rw = rw; bi3.addr = a; bi3.wr_data = d; end
    endcase
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b1, 1'b1, BUS_READ, '0, '0);
  endtask

  function automatic logic get_rdy(input int sel);
    case (sel)
      0: return bi0.rdy_;
      1: return bi1.rdy_;
      default: return bi3.rdy_;
    endcase
  endfunction

  function automatic word_data_t get_rd(input int sel);
    case (sel)
      0: return bi0.rd_data;
      1: return bi1.rd_data;
      default: return bi3.rd_data;
    endcase
  endfunction

  // One transfer; the request lines are scrambled right after acceptance.
  task automatic do_xfer(input int sel, input bus_rw_e rw, input word_addr_t a, input word_data_t d,
                         output int lat, output word_data_t rd, output logic post_rdy, output int leak);
    lat = -1; rd = '0; post_rdy = 1'b0; leak = 0;
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, rw, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b1, 1'b1, bus_rw_e'(1'($urandom_range(0, 1))), word_addr_t'($urandom), word_data_t'($urandom));
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (get_rdy(sel) == 1'b0) begin
        lat = k; rd = get_rd(sel);
        break;
      end
      if (get_rd(sel) != '0) leak++;
    end
    if (lat >= 0) begin
      @(negedge clk);
      post_rdy = get_rdy(sel);
      if (get_rd(sel) != '0) leak++;
    end
  endtask

  task automatic test_reset();
    int sels [3] = '{0, 1, 3};
    rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
    idle(0); idle(1); idle(3);
    repeat (3) @(negedge clk);
    foreach (sels[i]) begin
      total++;
      if (get_rdy(sels[i]) !== 1'b1) begin bad++; $display("FAIL reset_rdy dut%0d: got %b want 1", sels[i], get_rdy(sels[i])); end
      total++;
      if (get_rd(sels[i]) !== '0) begin bad++; $display("FAIL reset_rd dut%0d: got %h want 0", sels[i], get_rd(sels[i])); end
    end
    @(posedge clk); #1;
    rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
  endtask

  task automatic test_write_read();
    int lat, leak; word_data_t rd; logic prdy;
    do_xfer(1, BUS_WRITE, 30'h005, 32'hDEADBEEF, lat, rd, prdy, leak);
    model[key(1, 30'h005)] = 32'hDEADBEEF;
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    total++; if (rd !== '0) begin bad++; $display("FAIL wr_rd_data: got %h want 0", rd); end
    total++; if (prdy !== 1'b1) begin bad++; $display("FAIL wr_rdy_width: got %b want 1", prdy); end
    do_xfer(1, BUS_READ, 30'h005, 32'h0, lat, rd, prdy, leak);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
    total++; if (rd !== model[key(1, 30'h005)]) begin bad++; $display("FAIL rd_data: got %h want %h", rd, model[key(1, 30'h005)]); end
    total++; if (leak !== 0) begin bad++; $display("FAIL rd_idle_zero: got %0d nonzero want 0", leak); end
  endtask

  task automatic test_alias();
    int lat, leak; word_data_t rd; logic prdy;
    do_xfer(0, BUS_WRITE, 30'h005, 32'h12345678, lat, rd, prdy, leak);
    model[key(0, 30'h005)] = 32'h12345678;
    total++; if (lat !== 1) begin bad++; $display("FAIL w0_latency: got %0d want 1", lat); end
    do_xfer(0, BUS_READ, 30'h405, 32'h0, lat, rd, prdy, leak);
    total++; if (lat !== 1) begin bad++; $display("FAIL alias_latency: got %0d want 1", lat); end
    total++; if (rd !== model[key(0, 30'h405)]) begin bad++; $display("FAIL alias_data: got %h want %h", rd, model[key(0, 30'h405)]); end
    total++; if (prdy !== 1'b1) begin bad++; $display("FAIL alias_rdy_width: got %b want 1", prdy); end
  endtask

  task automatic test_back_to_back();
    int w = 1; int pulses [$]; int leak = 0; word_data_t expv;
    expv = model[key(1, 30'h005)];
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, BUS_READ, 30'h005, '0);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      if (e == 1 + 2 * (w + 2)) begin #1; idle(1); end
      @(negedge clk);
      if (get_rdy(1) == 1'b0) begin
        pulses.push_back(e);
        total++; if (get_rd(1) !== expv) begin bad++; $display("FAIL b2b_data e%0d: got %h want %h", e, get_rd(1), expv); end
      end else if (get_rd(1) != '0) begin
        leak++;
      end
    end
    total++; if (pulses.size() !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", pulses.size()); end
    for (int i = 0; i < pulses.size() && i < 3; i++) begin
      total++;
      if (pulses[i] !== 1 + i * (w + 2) + w + 1) begin bad++; $display("FAIL b2b_pos%0d: got %0d want %0d", i, pulses[i], 1 + i * (w + 2) + w + 1); end
    end
    total++; if (leak !== 0) begin bad++; $display("FAIL b2b_gap_zero: got %0d nonzero want 0", leak); end
  endtask

  task automatic test_raw();
    int pulses [$]; word_data_t rds [$]; word_data_t val;
    val = word_data_t'($urandom);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, BUS_WRITE, 30'h033, val);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      if (e == 1) begin #1; drive(0, 1'b0, 1'b0, BUS_READ, 30'h033, word_data_t'($urandom)); end
      if (e == 3) begin #1; idle(0); end
      @(negedge clk);
      if (get_rdy(0) == 1'b0) begin pulses.push_back(e); rds.push_back(get_rd(0)); end
    end
    model[key(0, 30'h033)] = val;
    total++; if (pulses.size() !== 2) begin bad++; $display("FAIL raw_count: got %0d want 2", pulses.size()); end
    if (pulses.size() == 2) begin
      total++; if (pulses[0] !== 2 || pulses[1] !== 4) begin bad++; $display("FAIL raw_pos: got %0d,%0d want 2,4", pulses[0], pulses[1]); end
      total++; if (rds[0] !== '0) begin bad++; $display("FAIL raw_wr_data: got %h want 0", rds[0]); end
      total++; if (rds[1] !== val) begin bad++; $display("FAIL raw_rd_data: got %h want %h", rds[1], val); end
    end
  endtask

  task automatic test_abort();
    int lat, leak; word_data_t rd; logic prdy; int lows = 0; int dirty = 0;
    do_xfer(3, BUS_WRITE, 30'h010, 32'h11111111, lat, rd, prdy, leak);
    model[key(3, 30'h010)] = 32'h11111111;
    total++; if (lat !== 4) begin bad++; $display("FAIL w3_latency: got %0d want 4", lat); end
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, BUS_WRITE, 30'h010, 32'h00000001);
    @(posedge clk); #1;
    idle(3);
    @(posedge clk); #2;
    rst3 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (get_rdy(3) == 1'b0) lows++;
      if (get_rd(3) != '0) dirty++;
    end
    @(posedge clk); #1;
    rst3 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (get_rdy(3) == 1'b0) lows++;
      if (get_rd(3) != '0) dirty++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL abort_rdy: got %0d pulses want 0", lows); end
    total++; if (dirty !== 0) begin bad++; $display("FAIL abort_rd_zero: got %0d nonzero want 0", dirty); end
    do_xfer(3, BUS_READ, 30'h010, 32'h0, lat, rd, prdy, leak);
    total++; if (lat !== 4) begin bad++; $display("FAIL abort_rd_latency: got %0d want 4", lat); end
    total++; if (rd !== model[key(3, 30'h010)]) begin bad++; $display("FAIL abort_rd_data: got %h want %h", rd, model[key(3, 30'h010)]); end
  endtask

  task automatic test_no_cs();
    int lat, leak; word_data_t rd; logic prdy;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b0, BUS_WRITE, 30'h005, word_data_t'($urandom));
      @(negedge clk);
      total++; if (get_rdy(1) !== 1'b1) begin bad++; $display("FAIL nocs_rdy c%0d: got %b want 1", c, get_rdy(1)); end
      total++; if (get_rd(1) !== '0) begin bad++; $display("FAIL nocs_rd c%0d: got %h want 0", c, get_rd(1)); end
    end
    @(posedge clk); #1;
    idle(1);
    do_xfer(1, BUS_READ, 30'h005, 32'h0, lat, rd, prdy, leak);
    total++; if (rd !== model[key(1, 30'h005)]) begin bad++; $display("FAIL nocs_mem: got %h want %h", rd, model[key(1, 30'h005)]); end
  endtask

  task automatic test_hold_inputs();
    int lat, leak; word_data_t rd; logic prdy;
    do_xfer(1, BUS_WRITE, 30'h020, 32'hA5A5A5A5, lat, rd, prdy, leak);
    model[key(1, 30'h020)] = 32'hA5A5A5A5;
    do_xfer(1, BUS_READ, 30'h020, 32'h0, lat, rd, prdy, leak);
    total++; if (rd !== model[key(1, 30'h020)]) begin bad++; $display("FAIL hold_data: got %h want %h", rd, model[key(1, 30'h020)]); end
  endtask

  task automatic test_random();
    int sels [3] = '{0, 1, 3};
    int lat, leak; word_data_t rd, d; logic prdy; word_addr_t a; int k;
    foreach (sels[s]) begin
      for (int n = 0; n < 20; n++) begin
        a = word_addr_t'(($urandom << 10) | (32'h100 + $urandom_range(0, 7)));
        d = word_data_t'($urandom);
        k = key(sels[s], a);
        if (!model.exists(k) || $urandom_range(0, 1) == 0) begin
          do_xfer(sels[s], BUS_WRITE, a, d, lat, rd, prdy, leak);
          model[k] = d;
          total++; if (rd !== '0) begin bad++; $display("FAIL rnd_wr_rd dut%0d n%0d: got %h want 0", sels[s], n, rd); end
        end else begin
          do_xfer(sels[s], BUS_READ, a, d, lat, rd, prdy, leak);
          total++; if (rd !== model[k]) begin bad++; $display("FAIL rnd_rd dut%0d n%0d: got %h want %h", sels[s], n, rd, model[k]); end
        end
        total++; if (lat !== sels[s] + 1) begin bad++; $display("FAIL rnd_lat dut%0d n%0d: got %0d want %0d", sels[s], n, lat, sels[s] + 1); end
        total++; if (prdy !== 1'b1 || leak !== 0) begin bad++; $display("FAIL rnd_pulse dut%0d n%0d: got rdy=%b leak=%0d want 1/0", sels[s], n, prdy, leak); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_raw();
    test_abort();
    test_no_cs();
    test_hold_inputs();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
